// File: rtl/status_seg_display_pkg.sv
// Shared types and constants for the status display: FSM states, sizes,
// segment glyphs and the double-dabble step.
package status_seg_display_pkg;
    typedef enum logic [1:0] {IDLE, CONV_A, CONV_V, COMMIT} state_t;

    localparam int DIGITS    = 6;
    localparam int LINE_BITS = 8;
    localparam int VAL_BITS  = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // One double-dabble iteration on three BCD nibbles: add-3 then shift in din.
    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic din);
        logic [11:0] adj;
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return {adj[10:0], din};
    endfunction
endpackage

// File: rtl/status_seg_display_if.sv
// Core-debug-to-display bundle: numbers in, segment/anode drive and busy out.
interface status_seg_display_if;
    import status_seg_display_pkg::*;

    logic [LINE_BITS-1:0] line_no;
    logic [VAL_BITS-1:0]  value;
    logic [6:0]           seg;
    logic [DIGITS-1:0]    an;
    logic                 busy;

    modport master (output line_no, value, input seg, an, busy);
    modport slave  (input line_no, value, output seg, an, busy);
endinterface

// File: rtl/status_seg_display_bcd_seg_decode.sv
// BCD nibble to active-low seven-segment glyph; illegal nibbles show a dash.
module bcd_seg_decode
    import status_seg_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/status_seg_display.sv
// Six-digit status display: line number (left) and register value (right),
// converted to decimal sequentially and scanned onto a common-anode display.
module status_seg_display
    import status_seg_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    status_seg_display_if.slave bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t                   state_q, state_d;
    logic [2:0]               iter_q;
    logic [LINE_BITS-1:0]     snap_line_q;
    logic [VAL_BITS-1:0]      snap_val_q;
    logic                     valid_q;
    logic [11:0]              bcd_a_q, bcd_v_q;
    logic [DIGITS-1:0][3:0]   digit_q;
    logic [RW-1:0]            ref_cnt_q;
    logic [2:0]               idx_q;
    logic [6:0]               seg_q, seg_dec;
    logic [DIGITS-1:0]        an_q;
    logic                     start;
    logic [3:0]               cur, hun, ten;
    logic                     blank;

    // A fresh conversion is needed until something is shown, or when the inputs move.
    assign start = (state_q == IDLE) &&
                   (!valid_q || {bus.line_no, bus.value} != {snap_line_q, snap_val_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV_A;
            CONV_A:  if (iter_q == 3'd7) state_d = CONV_V;
            CONV_V:  if (iter_q == 3'd6) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_line_q <= '0;
            snap_val_q  <= '0;
            bcd_a_q     <= '0;
            bcd_v_q     <= '0;
            iter_q      <= '0;
            digit_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    snap_line_q <= bus.line_no;
                    snap_val_q  <= bus.value;
                    bcd_a_q     <= '0;
                    bcd_v_q     <= '0;
                    iter_q      <= '0;
                end
                CONV_A: begin
                    bcd_a_q <= dd_step(bcd_a_q, snap_line_q[3'd7 - iter_q]);
                    iter_q  <= iter_q + 3'd1;
                end
                CONV_V: begin
                    bcd_v_q <= dd_step(bcd_v_q, snap_val_q[3'd6 - iter_q]);
                    iter_q  <= (iter_q == 3'd6) ? 3'd0 : iter_q + 3'd1;
                end
                COMMIT: begin
                    // All six digits swap in one edge so the display never tears.
                    digit_q <= {bcd_a_q, bcd_v_q};
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            idx_q     <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    // Leading-zero blanking looks at the hundreds/tens of the group being scanned.
    always_comb begin
        cur   = digit_q[idx_q];
        hun   = (idx_q >= 3'd3) ? digit_q[5] : digit_q[2];
        ten   = (idx_q >= 3'd3) ? digit_q[4] : digit_q[1];
        blank = 1'b0;
        if (BLANK_LEADING) begin
            case (idx_q)
                3'd2, 3'd5: blank = (hun == 4'd0);
                3'd1, 3'd4: blank = (hun == 4'd0) && (ten == 4'd0);
                default:    blank = 1'b0;
            endcase
        end
    end

    bcd_seg_decode u_dec (
        .bcd   (cur),
        .blank (blank),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= valid_q ? ~(6'b000001 << idx_q) : '1;
            seg_q <= valid_q ? seg_dec : SEG_BLANK;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg  = seg_q;
    assign bus.busy = (state_q != IDLE);
endmodule
